fmrv32im_uart_rx: RTL and testbench

FMRV32IM_UART_RX -- requirements
Module: fmrv32im_uart_rx

---
 rtl/fmrv32im_uart_pkg.sv | 26 ++
 rtl/fmrv32im_uart_fifo.sv | 56 +++++
 rtl/fmrv32im_uart_rx.sv | 198 +++++++++++++++++++
 tb/tb_fmrv32im_uart_rx.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmrv32im_uart_pkg.sv
// Shared definitions for the fmrv32im UART receiver.
// Holds the receiver state encoding, the 16x oversample constant and the
// baud divider calculation used by fmrv32im_uart_rx.
// Build option: UART_RX_PARITY_EN adds the PARITY state (8E1 frames).
package fmrv32im_uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  // Clocks per oversample tick, integer truncated.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/fmrv32im_uart_fifo.sv
// Show-ahead receive FIFO for the fmrv32im UART receiver.
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset
//   wr_ena, wr_data  - push request and byte (dropped when full with no pop)
//   rd_ena           - pop head (ignored when empty)
//   rd_data          - head entry, valid while empty=0
//   empty, full      - occupancy status
module fmrv32im_uart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_ena,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ena,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             rd_ok_c;
  logic             wr_ok_c;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok_c = rd_ena && !empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign wr_ok_c = wr_ena && (!full || rd_ok_c);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage and pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '{default: '0};
    end else begin
      if (wr_ok_c) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (rd_ok_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/fmrv32im_uart_rx.sv
// fmrv32im UART receiver: 16x oversampled 8N1 (8E1 with UART_RX_PARITY_EN)
// receiver feeding a show-ahead byte FIFO, with sticky error flags.
// Ports:
//   CLK, RST_N          - clock, synchronous active-low reset
//   RXD                 - asynchronous serial input, idle high
//   RD_ENA              - pop FIFO head
//   RD_DATA             - FIFO head byte, valid while RD_EMPTY=0
//   RD_EMPTY, RD_FULL   - FIFO status
//   ERR_CLR             - clear sticky flags (a same-cycle set wins)
//   FRAME_ERR           - stop bit sampled low
//   OVERRUN             - byte dropped on a full FIFO
//   PARITY_ERR          - even parity mismatch (0 without UART_RX_PARITY_EN)
module fmrv32im_uart_rx
  import fmrv32im_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RXD,
  input  logic       RD_ENA,
  output logic [7:0] RD_DATA,
  output logic       RD_EMPTY,
  output logic       RD_FULL,
  input  logic       ERR_CLR,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       PARITY_ERR
);

  localparam int unsigned DIV_RAW = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam int unsigned DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TW      = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  logic          rxd_meta;
  logic          rxd_sync;
  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_nxt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_nxt;
  logic [7:0]    shift;
  logic [7:0]    shift_nxt;
  logic          tick_c;
  logic          push_c;
  logic          frame_set_c;
  logic          overrun_set_c;
`ifdef UART_RX_PARITY_EN
  logic          parity_set_c;
`endif

  // Divider is held at 0 in IDLE, so it restarts on every start edge.
  assign tick_c        = (state != ST_IDLE) && (div_cnt == DIV_LAST);
  assign overrun_set_c = push_c && RD_FULL && !RD_ENA;

  // Next-state, datapath and event decode.
  always_comb begin
    state_nxt   = state;
    div_nxt     = div_cnt;
    tick_nxt    = tick_cnt;
    bit_nxt     = bit_cnt;
    shift_nxt   = shift;
    push_c      = 1'b0;
    frame_set_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_set_c = 1'b0;
`endif

    if (state == ST_IDLE) begin
      div_nxt = '0;
    end else begin
      div_nxt = tick_c ? '0 : div_cnt + DW'(1);
    end
    if (tick_c) begin
      tick_nxt = tick_cnt + TW'(1);
    end

    case (state)
      ST_IDLE: begin
        tick_nxt = '0;
        bit_nxt  = '0;
        if (!rxd_sync) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        // Mid start bit: a high line means the edge was a glitch.
        if (tick_c && tick_cnt == TICK_MID) begin
          tick_nxt  = '0;
          state_nxt = rxd_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick_c && tick_cnt == TICK_LAST) begin
          shift_nxt = {rxd_sync, shift[7:1]};
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_c && tick_cnt == TICK_LAST) begin
          parity_set_c = ^{shift, rxd_sync};
          state_nxt    = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick_c && tick_cnt == TICK_LAST) begin
          if (rxd_sync) begin
            push_c    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            frame_set_c = 1'b1;
            state_nxt   = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxd_sync) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Synchroniser, state, datapath and sticky flags.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      state     <= ST_IDLE;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      rxd_meta  <= RXD;
      rxd_sync  <= rxd_meta;
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      shift     <= shift_nxt;
      FRAME_ERR <= frame_set_c || (FRAME_ERR && !ERR_CLR);
      OVERRUN   <= overrun_set_c || (OVERRUN && !ERR_CLR);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity flag, same set-over-clear priority as the others.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      PARITY_ERR <= 1'b0;
    end else begin
      PARITY_ERR <= parity_set_c || (PARITY_ERR && !ERR_CLR);
    end
  end
`else
  assign PARITY_ERR = 1'b0;
`endif

  fmrv32im_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .wr_ena  (push_c),
    .wr_data (shift),
    .rd_ena  (RD_ENA),
    .rd_data (RD_DATA),
    .empty   (RD_EMPTY),
    .full    (RD_FULL)
  );

endmodule

// File: tb/tb_fmrv32im_uart_rx.sv
// Self-checking bench for fmrv32im_uart_rx, run at a scaled clock/baud
// ratio (3 clocks per oversample tick, 48 clocks per bit) to keep runs short.
module tb_fmrv32im_uart_rx;

  localparam int unsigned CLK_FREQ = 48000000;
  localparam int unsigned BAUD     = 1000000;
  localparam int unsigned DEPTH    = 8;
  localparam int DIV      = int'(CLK_FREQ / (BAUD * 16));
  localparam int BIT_CLKS = DIV * 16;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Negedge index (start bit driven at index 0) of the stop-sample cycle:
  // 2 synchroniser clocks, then tick 8 of the start bit plus 16 ticks per
  // following bit.
  localparam int PUSH_CYC = 2 + (8 + 16 * (9 + PBITS)) * DIV;
  localparam int NV = 12;

  logic       CLK;
  logic       RST_N;
  logic       RXD;
  logic       RD_ENA;
  logic [7:0] RD_DATA;
  logic       RD_EMPTY;
  logic       RD_FULL;
  logic       ERR_CLR;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic       PARITY_ERR;

  int total;
  int bad;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_empty;
    logic       exp_full;
    logic [7:0] exp_head;
    logic       exp_fe;
    logic       exp_ov;
    int         pops;
    logic       clr;
  } vec_t;

  vec_t       vecs [NV];
  logic [7:0] q [$];
  logic       m_fe;
  logic       m_ov;
  logic       e_pre;
  logic       e_post;
  logic       fe_post;
  logic [7:0] rb;
  logic       rs;
  int         bc;
  int         np;

  fmrv32im_uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .RXD        (RXD),
    .RD_ENA     (RD_ENA),
    .RD_DATA    (RD_DATA),
    .RD_EMPTY   (RD_EMPTY),
    .RD_FULL    (RD_FULL),
    .ERR_CLR    (ERR_CLR),
    .FRAME_ERR  (FRAME_ERR),
    .OVERRUN    (OVERRUN),
    .PARITY_ERR (PARITY_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    repeat (200000) @(posedge CLK);
    $display("FAIL watchdog: still running after 200000 clocks, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One frame, LSB first; optional single-cycle RD_ENA / ERR_CLR pulses at
  // a given negedge index, and snapshots around the stop-sample cycle.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par_good,
                            input int bit_clks, input int pop_at, input int clr_at,
                            output logic s_pre, output logic s_post, output logic s_fe);
    logic [10:0] bits;
    int nbits;
    nbits = 10 + PBITS;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = data;
    if (PBITS == 1) begin
      bits[9]  = par_good ? ^data : ~^data;
      bits[10] = stop;
    end else begin
      bits[9] = stop;
    end
    s_pre = 1'bx;
    s_post = 1'bx;
    s_fe = 1'bx;
    for (int c = 0; c < nbits * bit_clks; c++) begin
      @(negedge CLK);
      if (c == PUSH_CYC) s_pre = RD_EMPTY;
      if (c == PUSH_CYC + 1) begin
        s_post = RD_EMPTY;
        s_fe   = FRAME_ERR;
      end
      RXD = bits[c / bit_clks];
      if (pop_at >= 0) RD_ENA = (c == pop_at);
      if (clr_at >= 0) ERR_CLR = (c == clr_at);
    end
    @(negedge CLK);
    RXD = 1'b1;
    RD_ENA = 1'b0;
    ERR_CLR = 1'b0;
  endtask

  task automatic send(input logic [7:0] data);
    logic a, b, c;
    send_frame(data, 1'b1, 1'b1, BIT_CLKS, -1, -1, a, b, c);
    idle(4);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, RD_DATA, exp);
    RD_ENA = 1'b1;
    @(negedge CLK);
    RD_ENA = 1'b0;
  endtask

  task automatic pulse_clr();
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    RST_N = 1'b0;
    RXD = 1'b1;
    RD_ENA = 1'b0;
    ERR_CLR = 1'b0;

    vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1, 1'b0};
    vecs[1] = '{8'hA3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1};
    vecs[2] = '{8'h12, 1'b1, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1, 1'b0};
    for (int k = 0; k < 9; k++) begin
      vecs[3 + k] = '{8'(k), 1'b1, 1'b0, (k >= 7), 8'h00, 1'b0, (k == 8), 0, 1'b0};
    end

    idle(4);
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst_empty", RD_EMPTY, 1);
    check("rst_full", RD_FULL, 0);
    check("rst_data", RD_DATA, 0);
    check("rst_fe", FRAME_ERR, 0);
    check("rst_ov", OVERRUN, 0);
    check("rst_pe", PARITY_ERR, 0);

    // Table: good byte, framing error, recovery, fill to overrun.
    for (int i = 0; i < NV; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, 1'b1, BIT_CLKS, -1, -1, e_pre, e_post, fe_post);
      idle(4);
      if (i == 0) begin
        check("push_cycle_pre_empty", e_pre, 1);
        check("push_cycle_post_empty", e_post, 0);
      end
      check($sformatf("v%0d_empty", i), RD_EMPTY, vecs[i].exp_empty);
      check($sformatf("v%0d_full", i), RD_FULL, vecs[i].exp_full);
      check($sformatf("v%0d_fe", i), FRAME_ERR, vecs[i].exp_fe);
      check($sformatf("v%0d_ov", i), OVERRUN, vecs[i].exp_ov);
      if (!vecs[i].exp_empty) check($sformatf("v%0d_head", i), RD_DATA, vecs[i].exp_head);
      for (int p = 0; p < vecs[i].pops; p++) begin
        RD_ENA = 1'b1;
        @(negedge CLK);
        RD_ENA = 1'b0;
      end
      if (vecs[i].clr) begin
        pulse_clr();
        check($sformatf("v%0d_clr_fe", i), FRAME_ERR, 0);
      end
    end

    // Drain the overrun fill: 0x00-0x07 in order, 0x08 dropped.
    for (int k = 0; k < 8; k++) pop_check($sformatf("drain_%0d", k), 8'(k));
    check("drain_empty", RD_EMPTY, 1);
    RD_ENA = 1'b1;
    @(negedge CLK);
    RD_ENA = 1'b0;
    check("pop_when_empty_ignored", RD_EMPTY, 1);
    check("ov_sticky", OVERRUN, 1);
    pulse_clr();
    check("ov_clr", OVERRUN, 0);

    // Push and pop on the same edge while full.
    for (int k = 0; k < 8; k++) send(8'h20 + 8'(k));
    check("fill2_full", RD_FULL, 1);
    send_frame(8'h28, 1'b1, 1'b1, BIT_CLKS, PUSH_CYC, -1, e_pre, e_post, fe_post);
    idle(4);
    check("pushpop_ov", OVERRUN, 0);
    check("pushpop_full", RD_FULL, 1);
    for (int k = 1; k < 9; k++) pop_check($sformatf("pushpop_%0d", k), 8'h20 + 8'(k));
    check("pushpop_empty", RD_EMPTY, 1);

    // A frame error landing on the same cycle as ERR_CLR still sets.
    send_frame(8'h3C, 1'b0, 1'b1, BIT_CLKS, -1, PUSH_CYC, e_pre, e_post, fe_post);
    idle(4);
    check("set_beats_clr", fe_post, 1);
    check("set_beats_clr_hold", FRAME_ERR, 1);
    check("fe_discard_empty", RD_EMPTY, 1);
    pulse_clr();

    // Short low glitch: no push, no flags, receiver ready again.
    @(negedge CLK);
    RXD = 1'b0;
    idle(11);
    RXD = 1'b1;
    idle(3 * BIT_CLKS);
    check("glitch_empty", RD_EMPTY, 1);
    check("glitch_fe", FRAME_ERR, 0);
    check("glitch_ov", OVERRUN, 0);
    send(8'hC5);
    pop_check("after_glitch", 8'hC5);

    // Reset in the middle of a frame with bytes queued.
    send(8'h61);
    send(8'h62);
    RXD = 1'b0;
    idle(100);
    RST_N = 1'b0;
    RXD = 1'b1;
    idle(3);
    RST_N = 1'b1;
    @(negedge CLK);
    check("midrst_empty", RD_EMPTY, 1);
    check("midrst_full", RD_FULL, 0);
    check("midrst_data", RD_DATA, 0);
    check("midrst_fe", FRAME_ERR, 0);
    send(8'h9A);
    check("midrst_fe_after", FRAME_ERR, 0);
    pop_check("midrst_next", 8'h9A);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, BIT_CLKS, -1, -1, e_pre, e_post, fe_post);
    idle(4);
    check("par_err", PARITY_ERR, 1);
    check("par_data", RD_DATA, 8'h07);
    pulse_clr();
    check("par_clr", PARITY_ERR, 0);
    pop_check("par_pop", 8'h07);
`endif

    // Randomised traffic against a queue model.
    q.delete();
    m_fe = 1'b0;
    m_ov = 1'b0;
    for (int n = 0; n < 30; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 7) != 0);
      bc = $urandom_range(BIT_CLKS - 1, BIT_CLKS + 1);
      send_frame(rb, rs, 1'b1, bc, -1, -1, e_pre, e_post, fe_post);
      if (!rs) m_fe = 1'b1;
      else if (q.size() < DEPTH) q.push_back(rb);
      else m_ov = 1'b1;
      idle($urandom_range(2, 12));
      check($sformatf("r%0d_empty", n), RD_EMPTY, (q.size() == 0));
      check($sformatf("r%0d_full", n), RD_FULL, (q.size() == DEPTH));
      check($sformatf("r%0d_fe", n), FRAME_ERR, m_fe);
      check($sformatf("r%0d_ov", n), OVERRUN, m_ov);
      check($sformatf("r%0d_pe", n), PARITY_ERR, 0);
      np = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) begin
        if (q.size() > 0) begin
          check($sformatf("r%0d_pop%0d", n, p), RD_DATA, q[0]);
          void'(q.pop_front());
        end
        RD_ENA = 1'b1;
        @(negedge CLK);
        RD_ENA = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        m_fe = 1'b0;
        m_ov = 1'b0;
      end
    end
    while (q.size() > 0) begin
      pop_check("r_drain", q[0]);
      void'(q.pop_front());
    end
    check("r_final_empty", RD_EMPTY, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
